instruction_fetch_unit: RTL

//  Requester side of the instruction-memory read interface: drives the word-aligned fetch address, honours
//  MEM_BUSYWAIT, and captures returned words into a small prefetch FIFO. Presents instructions and their
//  PC to the cpu_core decode stage over a valid/ready handshake. Handles branch/jump redirects, including
//  a redirect that arrives while a memory access is still outstanding.

---
 rtl/ifu_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instruction_fetch_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   ifu_state_t  - fetch state machine encoding (FETCH, HOLD, DISCARD)
//   fifo_entry_t - one prefetch FIFO entry {pc, instr}
//   align_pc     - clears the byte-offset bits of a PC
package ifu_pkg;

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} ifu_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fifo_entry_t;

    localparam int WORD_BYTES = 4;
    localparam logic [31:0] PC_INCR = 32'(WORD_BYTES);

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of {pc, instr} with flush.
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 empties the FIFO (dominates push/pop)
//   push, push_pc/instr   write one entry (never while full)
//   pop                   drop the head entry (never while empty)
//   head_pc/head_instr    current head, zero while empty
//   full, empty, count    occupancy
module fetch_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [31:0]   push_pc,
    input  logic [31:0]   push_instr,
    input  logic          pop,
    output logic [31:0]   head_pc,
    output logic [31:0]   head_instr,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    fifo_entry_t   mem_q [DEPTH];
    fifo_entry_t   mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = '{pc: push_pc, instr: push_instr};
        wr_d    = flush ? '0 : wr_q + AW'(push);
        rd_d    = flush ? '0 : rd_q + AW'(pop);
        count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign full       = count_q == (AW+1)'(DEPTH);
    assign empty      = count_q == '0;
    assign count      = count_q;
    assign head_pc    = empty ? '0 : mem_q[rd_q].pc;
    assign head_instr = empty ? '0 : mem_q[rd_q].instr;

    assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches words from instruction memory into a prefetch FIFO
// and hands them with their PC to decode over a valid/ready handshake.
//   CLK, RESET_N                      clock, asynchronous active-low reset
//   MEM_READ, MEM_READ_ADDRESS        fetch request and word-aligned address
//   MEM_READ_DATA, MEM_BUSYWAIT       returned word, wait indication
//   REDIRECT, REDIRECT_PC             branch/jump restart pulse and target
//   INSTR_VALID, INSTR, INSTR_PC      FIFO head towards decode
//   INSTR_READY                       decode accepts the head
//   FETCH_MISALIGNED                  sticky misaligned-target flag (IFU_MISALIGN_CHECK_EN only)
// Build option IFU_MISALIGN_CHECK_EN: a misaligned redirect target freezes the unit instead
// of being silently aligned.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic        MEM_READ,
    output logic [31:0] MEM_READ_ADDRESS,
    input  logic [31:0] MEM_READ_DATA,
    input  logic        MEM_BUSYWAIT,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        INSTR_VALID,
    output logic [31:0] INSTR,
    output logic [31:0] INSTR_PC,
    input  logic        INSTR_READY
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic        FETCH_MISALIGNED
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    ifu_state_t  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic        started_q;
    logic        misaligned_q, misaligned_d;
    logic        push, pop, flush, accept;
    logic        fifo_full, fifo_empty;
    logic [AW:0] fifo_count;
    logic [31:0] new_pc;

`ifdef IFU_MISALIGN_CHECK_EN
    assign misaligned_d = misaligned_q | (REDIRECT & (|REDIRECT_PC[1:0]));
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) misaligned_q <= 1'b0;
        else          misaligned_q <= misaligned_d;
    end
    assign FETCH_MISALIGNED = misaligned_q;
`else
    assign misaligned_d = 1'b0;
    assign misaligned_q = 1'b0;
`endif

    // The first request goes out one edge after reset release.
    assign MEM_READ         = (state_q == DISCARD) || (state_q == FETCH && started_q);
    assign MEM_READ_ADDRESS = fetch_pc_q;
    assign accept           = MEM_READ && !MEM_BUSYWAIT;
    assign pop              = INSTR_VALID && INSTR_READY;
    assign flush            = REDIRECT;
    assign new_pc           = align_pc(REDIRECT_PC);

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        push         = 1'b0;
        case (state_q)
            FETCH: begin
                if (REDIRECT && MEM_READ && MEM_BUSYWAIT) begin
                    // Address must stay put until the in-flight word returns.
                    pending_pc_d = new_pc;
                    state_d      = DISCARD;
                end else if (REDIRECT) begin
                    fetch_pc_d = new_pc;
                    state_d    = misaligned_d ? HOLD : FETCH;
                end else if (accept) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_INCR;
                    state_d    = (fifo_count == (AW+1)'(FIFO_DEPTH - 1) && !pop) ? HOLD : FETCH;
                end
            end
            HOLD: begin
                if (REDIRECT) begin
                    fetch_pc_d = new_pc;
                    state_d    = misaligned_d ? HOLD : FETCH;
                end else begin
                    state_d = (!fifo_full && !misaligned_q) ? FETCH : HOLD;
                end
            end
            DISCARD: begin
                if (REDIRECT) pending_pc_d = new_pc;
                if (accept) begin
                    fetch_pc_d = REDIRECT ? new_pc : pending_pc_q;
                    state_d    = misaligned_d ? HOLD : FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= '0;
            started_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            started_q    <= 1'b1;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .flush      (flush),
        .push       (push),
        .push_pc    (fetch_pc_q),
        .push_instr (MEM_READ_DATA),
        .pop        (pop),
        .head_pc    (INSTR_PC),
        .head_instr (INSTR),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign INSTR_VALID = !fifo_empty;

endmodule
